// File: rtl/reaction_pkg.sv
// Shared types and helpers for the multi-round reaction timer.
package reaction_pkg;

  typedef enum logic [2:0] {
    MODE_HI,
    MODE_BLANK,
    MODE_COUNT,
    MODE_RESULT,
    MODE_ERR_EARLY,
    MODE_ERR_TIMEOUT,
    MODE_AVG
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RAND,
    S_TIMING,
    S_RESULT,
    S_ERR_EARLY,
    S_ERR_TIMEOUT,
    S_AVG
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/reaction_timer_mr_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR that supplies the random delay bits.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= seed;
    else       q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/reaction_timer_mr.sv
// Multi-round reaction timer core: random delay, reaction measurement, best time.
// Optional 4-round averaging is enabled by defining REACTION_AVG_EN.
module reaction_timer_mr
  import reaction_pkg::*;
#(
  parameter int          CLK_HZ       = 100000000,
  parameter int          MIN_DELAY_MS = 2000,
  parameter int          DLY_W        = 12,
  parameter int          TIMEOUT_MS   = 1000,
  parameter int          RES_W        = 14,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clr_best,
  output logic             led,
  output mode_t            mode,
  output logic [RES_W-1:0] value,
  output logic             result_valid,
  output logic [RES_W-1:0] best
);

  localparam int DIV  = ms_div(CLK_HZ);
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DMAX = MIN_DELAY_MS + (1 << DLY_W);
  localparam int CMAX = (DMAX > TIMEOUT_MS) ? DMAX : TIMEOUT_MS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [15:0] DLY_MASK = 16'((1 << DLY_W) - 1);

  state_t           state;
  logic [PW-1:0]    pre;
  logic             tick;
  logic [CW-1:0]    ms_cnt;
  logic [CW-1:0]    delay_target;
  logic [15:0]      lfsr_q;
  logic [RES_W-1:0] cap;

  lfsr16 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .seed (SEED),
    .q    (lfsr_q)
  );

  assign tick = (pre == PW'(DIV - 1));
  assign cap  = RES_W'(ms_cnt);

`ifdef REACTION_AVG_EN
  logic [1:0]       rnd;
  logic [RES_W+1:0] sum;
  logic [RES_W+1:0] sum_next;
  assign sum_next = sum + (RES_W+2)'(cap);
`endif

  // Every state change clears the prescaler so each phase starts on a fresh ms boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      led          <= 1'b0;
      mode         <= MODE_HI;
      value        <= '0;
      result_valid <= 1'b0;
      best         <= '1;
      pre          <= '0;
      ms_cnt       <= '0;
      delay_target <= '0;
`ifdef REACTION_AVG_EN
      rnd          <= '0;
      sum          <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      pre          <= tick ? '0 : pre + 1'b1;
      if (clr_best) best <= '1;

      case (state)
        S_IDLE, S_RESULT, S_ERR_EARLY, S_ERR_TIMEOUT, S_AVG: begin
          if (start) begin
            state        <= S_WAIT_RAND;
            delay_target <= CW'(32'(MIN_DELAY_MS) + 32'(lfsr_q & DLY_MASK));
            ms_cnt       <= '0;
            pre          <= '0;
            led          <= 1'b0;
            mode         <= MODE_BLANK;
            value        <= '0;
          end
        end

        S_WAIT_RAND: begin
          if (stop) begin
            state <= S_ERR_EARLY;
            pre   <= '0;
            led   <= 1'b0;
            mode  <= MODE_ERR_EARLY;
            value <= '0;
          end else if (tick) begin
            if (ms_cnt == delay_target - 1'b1) begin
              state  <= S_TIMING;
              ms_cnt <= '0;
              pre    <= '0;
              led    <= 1'b1;
              mode   <= MODE_COUNT;
              value  <= '0;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end

        S_TIMING: begin
          if (stop) begin
            pre          <= '0;
            led          <= 1'b0;
            result_valid <= 1'b1;
            best         <= (cap < best) ? cap : best;
`ifdef REACTION_AVG_EN
            rnd <= rnd + 1'b1;
            if (rnd == 2'd3) begin
              state <= S_AVG;
              mode  <= MODE_AVG;
              value <= RES_W'(sum_next >> 2);
              sum   <= '0;
            end else begin
              state <= S_RESULT;
              mode  <= MODE_RESULT;
              value <= cap;
              sum   <= sum_next;
            end
`else
            state <= S_RESULT;
            mode  <= MODE_RESULT;
            value <= cap;
`endif
          end else if (tick) begin
            ms_cnt <= ms_cnt + 1'b1;
            if (ms_cnt == CW'(TIMEOUT_MS - 1)) begin
              state <= S_ERR_TIMEOUT;
              pre   <= '0;
              led   <= 1'b0;
              mode  <= MODE_ERR_TIMEOUT;
              value <= RES_W'(TIMEOUT_MS);
            end else begin
              value <= RES_W'(ms_cnt + 1'b1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
          led   <= 1'b0;
          mode  <= MODE_HI;
          value <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_mr.sv
// Scoreboard bench for reaction_timer_mr with a 4-cycle millisecond.
module tb_reaction_timer_mr;
  import reaction_pkg::*;

  localparam int          CLK_HZ       = 4000;
  localparam int          MIN_DELAY_MS = 3;
  localparam int          DLY_W        = 2;
  localparam int          TIMEOUT_MS   = 20;
  localparam int          RES_W        = 14;
  localparam logic [15:0] SEED         = 16'hACE1;
  localparam int          TPM          = 4;
  localparam int          NONE         = (1 << RES_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             clr_best = 1'b0;
  logic             led;
  mode_t            mode;
  logic [RES_W-1:0] value;
  logic             result_valid;
  logic [RES_W-1:0] best;

  typedef struct {
    int mode;
    int value;
    int best;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          exp_best = NONE;
  int          mrnd = 0;
  int          msum = 0;
  logic [15:0] mlfsr;

  reaction_timer_mr #(
    .CLK_HZ      (CLK_HZ),
    .MIN_DELAY_MS(MIN_DELAY_MS),
    .DLY_W       (DLY_W),
    .TIMEOUT_MS  (TIMEOUT_MS),
    .RES_W       (RES_W),
    .SEED        (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .clr_best    (clr_best),
    .led         (led),
    .mode        (mode),
    .value       (value),
    .result_valid(result_valid),
    .best        (best)
  );

  always #5 clk = ~clk;

  // Reference LFSR, used to predict the exact random delay of each round.
  always @(posedge clk or posedge reset) begin
    if (reset) mlfsr <= SEED;
    else       mlfsr <= {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  end

  task automatic checkOutput(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && result_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("result_mode", int'(mode), e.mode);
        checkOutput("result_value", int'(value), e.value);
        checkOutput("result_best", int'(best), e.best);
        checkOutput("result_led", int'(led), 0);
      end
    end
  end

  task automatic clearModel();
    exp_best = NONE;
    mrnd = 0;
    msum = 0;
    sb.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    clr_best = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clearModel();
  endtask

  task automatic beginRound(output bit ok);
    int k;
    int d;
    d = MIN_DELAY_MS + int'(mlfsr[DLY_W-1:0]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("mode_blank", int'(mode), int'(MODE_BLANK));
    checkOutput("led_off_wait", int'(led), 0);
    k = 0;
    ok = 1'b0;
    while (k < 200 && !ok) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (led) ok = 1'b1;
    end
    if (!ok) begin
      checkOutput("led_rise_timeout", 0, 1);
    end else begin
      checkOutput("led_delay_cycles", k, d * TPM);
      checkOutput("led_window", int'(k >= 3 * TPM && k <= 6 * TPM), 1);
      checkOutput("mode_count", int'(mode), int'(MODE_COUNT));
    end
  endtask

  task automatic pushExpected(input int r);
    exp_t e;
    if (r < exp_best) exp_best = r;
`ifdef REACTION_AVG_EN
    if (mrnd == 3) begin
      e.mode  = int'(MODE_AVG);
      e.value = (msum + r) >> 2;
      msum    = 0;
    end else begin
      e.mode  = int'(MODE_RESULT);
      e.value = r;
      msum    = msum + r;
    end
    mrnd = (mrnd + 1) % 4;
`else
    e.mode  = int'(MODE_RESULT);
    e.value = r;
`endif
    e.best = exp_best;
    sb.push_back(e);
  endtask

  // One full valid round: start, wait for the LED, stop after r ms.
  task automatic applyStimulus(input int r);
    bit ok;
    beginRound(ok);
    if (!ok) return;
    repeat (r * TPM) @(posedge clk);
    @(negedge clk);
    checkOutput("live_count", int'(value), r);
    pushExpected(r);
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stop = 1'b0;
    checkOutput("led_off_result", int'(led), 0);
    @(negedge clk);
    checkOutput("rv_one_cycle", int'(result_valid), 0);
    checkOutput("sb_drained", sb.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit ok;
    int k;

    doReset();
    checkOutput("reset_led", int'(led), 0);
    checkOutput("reset_mode", int'(mode), int'(MODE_HI));
    checkOutput("reset_value", int'(value), 0);
    checkOutput("reset_rv", int'(result_valid), 0);
    checkOutput("reset_best", int'(best), NONE);

    // Normal round
    applyStimulus(7);
    checkOutput("best_after_7", int'(best), 7);

    // Early press at 1 ms
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (TPM) @(posedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stop = 1'b0;
    checkOutput("early_mode", int'(mode), int'(MODE_ERR_EARLY));
    checkOutput("early_led", int'(led), 0);
    checkOutput("early_value", int'(value), 0);
    checkOutput("early_best", int'(best), 7);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    checkOutput("early_stop_ignored", int'(mode), int'(MODE_ERR_EARLY));

    // Timeout
    beginRound(ok);
    if (ok) begin
      k = 0;
      while (k < 200 && mode != MODE_ERR_TIMEOUT) begin
        @(posedge clk);
        k++;
        @(negedge clk);
      end
      checkOutput("timeout_cycles", k, TIMEOUT_MS * TPM);
      checkOutput("timeout_value", int'(value), TIMEOUT_MS);
      checkOutput("timeout_led", int'(led), 0);
      checkOutput("timeout_best", int'(best), 7);
    end

    // Best tracking and clear
    doReset();
    applyStimulus(9);
    applyStimulus(5);
    applyStimulus(12);
    checkOutput("best_min", int'(best), 5);
    clr_best = 1'b1;
    @(negedge clk);
    clr_best = 1'b0;
    checkOutput("best_cleared", int'(best), NONE);
    exp_best = NONE;
    applyStimulus(8);
    checkOutput("best_after_clear", int'(best), 8);

    // Asynchronous reset in the middle of TIMING
    beginRound(ok);
    repeat (4 * TPM) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_led", int'(led), 0);
    checkOutput("async_mode", int'(mode), int'(MODE_HI));
    checkOutput("async_best", int'(best), NONE);
    @(negedge clk);
    reset = 1'b0;
    clearModel();
    applyStimulus(3);
    checkOutput("best_after_reset", int'(best), 3);

    // Four-round sequence (average when the option is built in)
    doReset();
    applyStimulus(4);
    applyStimulus(6);
    applyStimulus(8);
    applyStimulus(11);
    applyStimulus(2);
    checkOutput("final_best", int'(best), 2);

    checkOutput("sb_empty_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
